// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch
// Purpose  : Instruction memory with loader write port and IF/ID register.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
    parameter int          MEM_DEPTH = 64,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        i_reset,
    input  logic [31:0] i_pc,
    input  logic        i_stall,
    input  logic        i_halt,
    input  logic        i_flush,
    input  logic        i_inst_we,
    input  logic [31:0] i_inst_addr,
    input  logic [31:0] i_inst_data,
    output logic [31:0] o_instruction,
    output logic [31:0] o_pc_plus4,
    output logic        o_valid,
    output logic        o_halt_fetched
);

    localparam int          c_ADDR_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [32:0] c_MEM_BYTES = 33'(MEM_DEPTH) << 2;

    logic [31:0] r_mem [MEM_DEPTH];

    logic [31:0] r_instruction;
    logic [31:0] r_pc_plus4;
    logic        r_valid;
    logic        r_halt_fetched;

    logic        w_fetch_in_range;
    logic        w_write_in_range;
    logic [31:0] w_fetch_word;
    logic [31:0] w_pc_plus4;
    logic        w_hold;

    assign w_fetch_in_range = ({1'b0, i_pc} < c_MEM_BYTES);
    assign w_write_in_range = ({1'b0, i_inst_addr} < c_MEM_BYTES);
    assign w_fetch_word     = w_fetch_in_range ? r_mem[i_pc[c_ADDR_W+1:2]] : 32'h0000_0000;
    assign w_pc_plus4       = i_pc + 32'd4;
    assign w_hold           = i_stall | i_halt;

    // Loader port is independent of reset and pipeline control; memory survives reset.
    always_ff @(posedge clk) begin
        if (i_inst_we && w_write_in_range) begin
            r_mem[i_inst_addr[c_ADDR_W+1:2]] <= i_inst_data;
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_instruction  <= 32'h0000_0000;
            r_pc_plus4     <= 32'h0000_0000;
            r_valid        <= 1'b0;
            r_halt_fetched <= 1'b0;
        end else if (i_flush) begin
            r_instruction  <= 32'h0000_0000;
            r_pc_plus4     <= w_pc_plus4;
            r_valid        <= 1'b0;
        end else if (!w_hold) begin
            r_instruction  <= w_fetch_word;
            r_pc_plus4     <= w_pc_plus4;
            r_valid        <= 1'b1;
            if (w_fetch_word == HALT_WORD) begin
                r_halt_fetched <= 1'b1;
            end
        end
    end

    assign o_instruction  = r_instruction;
    assign o_pc_plus4     = r_pc_plus4;
    assign o_valid        = r_valid;
    assign o_halt_fetched = r_halt_fetched;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch
// Purpose  : Directed self-checking bench for instruction_fetch.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

    logic        clk;
    logic        i_reset;
    logic [31:0] i_pc;
    logic        i_stall;
    logic        i_halt;
    logic        i_flush;
    logic        i_inst_we;
    logic [31:0] i_inst_addr;
    logic [31:0] i_inst_data;
    logic [31:0] o_instruction;
    logic [31:0] o_pc_plus4;
    logic        o_valid;
    logic        o_halt_fetched;

    int n_tests = 0;
    int n_fail  = 0;

    instruction_fetch #(
        .MEM_DEPTH (64),
        .HALT_WORD (32'hFFFF_FFFF)
    ) u_dut (
        .clk            (clk),
        .i_reset        (i_reset),
        .i_pc           (i_pc),
        .i_stall        (i_stall),
        .i_halt         (i_halt),
        .i_flush        (i_flush),
        .i_inst_we      (i_inst_we),
        .i_inst_addr    (i_inst_addr),
        .i_inst_data    (i_inst_data),
        .o_instruction  (o_instruction),
        .o_pc_plus4     (o_pc_plus4),
        .o_valid        (o_valid),
        .o_halt_fetched (o_halt_fetched)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] addr, input logic [31:0] data);
        i_inst_we   = 1'b1;
        i_inst_addr = addr;
        i_inst_data = data;
        tick();
        i_inst_we   = 1'b0;
    endtask

    task automatic expect_ifid(input string tag, input logic [31:0] inst,
                               input logic [31:0] pc4, input logic vld);
        check({tag, "_inst"},  o_instruction, inst);
        check({tag, "_pc4"},   o_pc_plus4,    pc4);
        check({tag, "_valid"}, {31'd0, o_valid}, {31'd0, vld});
    endtask

    initial begin
        i_reset     = 1'b1;
        i_pc        = 32'd0;
        i_stall     = 1'b0;
        i_halt      = 1'b0;
        i_flush     = 1'b0;
        i_inst_we   = 1'b0;
        i_inst_addr = 32'd0;
        i_inst_data = 32'd0;
        tick();
        expect_ifid("reset", 32'h0, 32'h0, 1'b0);
        check("reset_hf", {31'd0, o_halt_fetched}, 32'd0);

        // Program load while reset is held
        load(32'd0,  32'h2001_0005);
        load(32'd4,  32'h2002_0007);
        load(32'd8,  32'hFFFF_FFFF);
        load(32'd12, 32'h1234_5678);
        expect_ifid("reset_during_load", 32'h0, 32'h0, 1'b0);
        i_reset = 1'b0;

        i_pc = 32'd0; tick();
        expect_ifid("fetch0", 32'h2001_0005, 32'd4, 1'b1);
        i_pc = 32'd4; tick();
        expect_ifid("fetch4", 32'h2002_0007, 32'd8, 1'b1);

        // Stall holds for 3 cycles while pc moves
        i_pc = 32'd0; tick();
        i_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i_pc = 32'd4 + 32'(k) * 32'd4;
            tick();
            expect_ifid($sformatf("stall%0d", k), 32'h2001_0005, 32'd4, 1'b1);
        end
        i_stall = 1'b0;
        i_pc = 32'd4; tick();
        expect_ifid("after_stall", 32'h2002_0007, 32'd8, 1'b1);

        i_halt = 1'b1; i_pc = 32'd0; tick();
        expect_ifid("halt_hold", 32'h2002_0007, 32'd8, 1'b1);
        i_halt = 1'b0;

        // Flush beats stall; HALT_WORD at 8 is squashed
        i_flush = 1'b1; i_stall = 1'b1; i_pc = 32'd8; tick();
        expect_ifid("flush_stall", 32'h0, 32'd12, 1'b0);
        check("flush_hf", {31'd0, o_halt_fetched}, 32'd0);
        i_flush = 1'b0;
        tick();
        check("stall_blocks_hf", {31'd0, o_halt_fetched}, 32'd0);
        expect_ifid("stall_after_flush", 32'h0, 32'd12, 1'b0);
        i_stall = 1'b0;

        tick();
        expect_ifid("halt_word", 32'hFFFF_FFFF, 32'd12, 1'b1);
        check("hf_set", {31'd0, o_halt_fetched}, 32'd1);
        i_pc = 32'd12; tick();
        expect_ifid("after_halt", 32'h1234_5678, 32'd16, 1'b1);
        check("hf_sticky", {31'd0, o_halt_fetched}, 32'd1);

        // Out-of-range fetch and dropped out-of-range write
        i_pc = 32'd256; tick();
        expect_ifid("oor_fetch", 32'h0, 32'd260, 1'b1);
        load(32'd256, 32'hDEAD_BEEF);
        i_pc = 32'd0; tick();
        expect_ifid("oor_write_dropped", 32'h2001_0005, 32'd4, 1'b1);

        i_pc = 32'hFFFF_FFFC; tick();
        expect_ifid("pc_wrap", 32'h0, 32'h0, 1'b1);

        // Same-cycle read/write of word 1
        i_pc = 32'd4;
        load(32'd4, 32'hAAAA_0000);
        expect_ifid("rw_same_cycle", 32'h2002_0007, 32'd8, 1'b1);
        tick();
        expect_ifid("rw_next", 32'hAAAA_0000, 32'd8, 1'b1);

        // Reset during stall discards held state, keeps memory
        i_stall = 1'b1; i_reset = 1'b1; tick();
        expect_ifid("reset_mid_stall", 32'h0, 32'h0, 1'b0);
        check("reset_clears_hf", {31'd0, o_halt_fetched}, 32'd0);
        i_stall = 1'b0; i_reset = 1'b0; i_pc = 32'd5; tick();
        expect_ifid("mem_kept", 32'hAAAA_0000, 32'd9, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
